inv_mixcolumns: RTL and testbench

// - Iterative AES InvMixColumns engine for the decryption datapath; inverse of the mixcolumns block.
// - Accepts a 128-bit state after InvShiftRows/InvSubBytes and transforms one 32-bit column per cycle.
// - Streams each result column and holds the full 128-bit result.
// - Pairs with inverse sbox/shiftrows stages to complete a decryption round.

---
 rtl/inv_mixcolumns_pkg.sv | 80 ++++++++
 rtl/inv_mixcolumns_if.sv | 33 +++
 rtl/inv_mixcolumn_word.sv | 22 ++
 rtl/inv_mixcolumns.sv | 105 ++++++++++
 tb/tb_inv_mixcolumns.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/inv_mixcolumns_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES InvMixColumns engine.
// FSM encodings, field polynomial, xtime/gmul chain and column slice/insert helpers.
package inv_mixcolumns_pkg;

  localparam int NCOL  = 4;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOL - 1);
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Column 0 is the most significant word (FIPS-197 byte order).
  function automatic logic [31:0] col_of(input logic [127:0] s, input logic [CNT_W-1:0] c);
    logic [31:0] w;
    case (c)
      2'd0:    w = s[127:96];
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      2'd3:    w = s[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic [127:0] col_put(input logic [127:0] s, input logic [CNT_W-1:0] c,
                                           input logic [31:0] w);
    logic [127:0] r;
    r = s;
    case (c)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mixcolumns_if.sv
// Request/result bundle of the InvMixColumns engine; master drives requests, slave is the engine.
// The rkey signal exists only when INV_MIX_ADDKEY_EN is defined.
interface inv_mixcolumns_if;
  import inv_mixcolumns_pkg::*;

  logic             enable;
  logic [127:0]     istate;
`ifdef INV_MIX_ADDKEY_EN
  logic [127:0]     rkey;
`endif
  logic [127:0]     ostate;
  logic [31:0]      mout;
  logic             mvalid;
  logic [CNT_W-1:0] mcol;
  logic             done;

  modport master (
`ifdef INV_MIX_ADDKEY_EN
    output rkey,
`endif
    output enable, istate,
    input  ostate, mout, mvalid, mcol, done
  );

  modport slave (
`ifdef INV_MIX_ADDKEY_EN
    input  rkey,
`endif
    input  enable, istate,
    output ostate, mout, mvalid, mcol, done
  );

endinterface

// File: rtl/inv_mixcolumn_word.sv
// Combinational InvMixColumns on one 32-bit column, byte0 in the MSB.
module inv_mixcolumn_word
  import inv_mixcolumns_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] s0_s, s1_s, s2_s, s3_s;
  logic [7:0] r0_s, r1_s, r2_s, r3_s;

  assign {s0_s, s1_s, s2_s, s3_s} = col_i;

  // Circulant matrix rows {0e,0b,0d,09} rotated right by one per output byte.
  assign r0_s = gmul14(s0_s) ^ gmul11(s1_s) ^ gmul13(s2_s) ^ gmul9(s3_s);
  assign r1_s = gmul9(s0_s)  ^ gmul14(s1_s) ^ gmul11(s2_s) ^ gmul13(s3_s);
  assign r2_s = gmul13(s0_s) ^ gmul9(s1_s)  ^ gmul14(s2_s) ^ gmul11(s3_s);
  assign r3_s = gmul11(s0_s) ^ gmul13(s1_s) ^ gmul9(s2_s)  ^ gmul14(s3_s);

  assign col_o = {r0_s, r1_s, r2_s, r3_s};

endmodule

// File: rtl/inv_mixcolumns.sv
// Iterative AES InvMixColumns engine: one column per cycle, streamed and collected into ostate.
// Optional INV_MIX_ADDKEY_EN folds AddRoundKey into the capture.
module inv_mixcolumns
  import inv_mixcolumns_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  inv_mixcolumns_if.slave bus
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     latch_q;
  logic [127:0]     ostate_q;
  logic [31:0]      mout_q;
  logic             mvalid_q;
  logic [CNT_W-1:0] mcol_q;
  logic             done_q;

  logic [127:0]     capture_s;
  logic [31:0]      col_in_s;
  logic [31:0]      col_out_s;

  // Value captured on the start edge.
  always_comb begin
    capture_s = 128'h0;
`ifdef INV_MIX_ADDKEY_EN
    capture_s = bus.istate ^ bus.rkey;
`else
    capture_s = bus.istate;
`endif
  end

  assign col_in_s = col_of(latch_q, cnt_q);

  inv_mixcolumn_word u_word (
    .col_i (col_in_s),
    .col_o (col_out_s)
  );

  // Control FSM, column counter, input latch and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      latch_q  <= 128'h0;
      ostate_q <= 128'h0;
      mout_q   <= 32'h0;
      mvalid_q <= 1'b0;
      mcol_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mvalid_q <= 1'b0;
          done_q   <= 1'b0;
          if (bus.enable) begin
            latch_q <= capture_s;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          ostate_q <= col_put(ostate_q, cnt_q, col_out_s);
          mout_q   <= col_out_s;
          mcol_q   <= cnt_q;
          mvalid_q <= 1'b1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_COL) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            done_q  <= 1'b0;
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          mvalid_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= bus.enable ? ST_HOLD : ST_IDLE;
        end
        // Held-high enable parks here so it cannot retrigger a run.
        ST_HOLD: begin
          mvalid_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= bus.enable ? ST_HOLD : ST_IDLE;
        end
        default: begin
          mvalid_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ostate = ostate_q;
  assign bus.mout   = mout_q;
  assign bus.mvalid = mvalid_q;
  assign bus.mcol   = mcol_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_inv_mixcolumns.sv
// Scoreboard bench for inv_mixcolumns: expected beats queued at start, checked as mvalid beats arrive.
module tb_inv_mixcolumns;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inv_mixcolumns_if bus ();

  inv_mixcolumns dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [33:0]  sb[$];
  logic [33:0]  ent;
  logic [127:0] rkey_v = 128'h0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: generic shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {gm(s0, 8'd14) ^ gm(s1, 8'd11) ^ gm(s2, 8'd13) ^ gm(s3, 8'd9),
            gm(s0, 8'd9)  ^ gm(s1, 8'd14) ^ gm(s2, 8'd11) ^ gm(s3, 8'd13),
            gm(s0, 8'd13) ^ gm(s1, 8'd9)  ^ gm(s2, 8'd14) ^ gm(s3, 8'd11),
            gm(s0, 8'd11) ^ gm(s1, 8'd13) ^ gm(s2, 8'd9)  ^ gm(s3, 8'd14)};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(st[127-32*c -: 32]);
    return r;
  endfunction

  // Beat monitor: every mvalid beat pops one expected {mcol, mout}.
  always @(negedge clk) begin
    if (resetn && bus.mvalid) begin
      if (sb.size() == 0) begin
        chk("beat_without_stimulus", bus.mvalid, 1'b0);
      end else begin
        ent = sb.pop_front();
        chk("mcol", bus.mcol, ent[33:32]);
        chk("mout", bus.mout, ent[31:0]);
        chk("done_on_beat", bus.done, ent[33:32] == 2'd3);
      end
    end
  end

  task automatic push_exp(input logic [127:0] exp);
    logic [1:0] cc;
    for (int c = 0; c < 4; c++) begin
      cc = c[1:0];
      sb.push_back({cc, exp[127-32*c -: 32]});
    end
  endtask

  // Called at a negedge with the DUT idle; hold = negedges enable stays high.
  task automatic run_vec(input string tag, input logic [127:0] st, input logic [127:0] exp,
                         input int hold, input bit toggle);
    int dn;
    int lim;
    dn = 0;
    lim = (hold > 12) ? hold : 12;
    push_exp(exp);
`ifdef INV_MIX_ADDKEY_EN
    bus.rkey = rkey_v;
`endif
    bus.istate = st;
    bus.enable = 1'b1;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      if (n >= hold) bus.enable = 1'b0;
      if (toggle) bus.istate = {4{$urandom()}};
      if (bus.done) begin
        dn++;
        chk({tag, "_ostate"}, bus.ostate, exp);
      end
    end
    bus.enable = 1'b0;
    chk({tag, "_done_count"}, dn, 1);
    chk({tag, "_beats_left"}, sb.size(), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic reset_mid_run(input logic [127:0] st);
    int nb;
    nb = 0;
    push_exp(model(st ^ rkey_v));
    bus.istate = st;
    bus.enable = 1'b1;
    for (int n = 1; n <= 12 && nb < 2; n++) begin
      @(negedge clk);
      bus.enable = 1'b0;
      if (bus.mvalid) nb++;
    end
    chk("rst_beats_before", nb, 2);
    resetn = 1'b0;
    #1;
    chk("rst_mvalid", bus.mvalid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ostate", bus.ostate, 128'h0);
    chk("rst_mout", bus.mout, 32'h0);
    chk("rst_mcol", bus.mcol, 2'd0);
    sb.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_no_done", bus.done, 1'b0);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  logic [127:0] rnd_st;

  initial begin
    bus.enable = 1'b0;
    bus.istate = 128'h0;
`ifdef INV_MIX_ADDKEY_EN
    bus.rkey = 128'h0;
`endif
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mvalid", bus.mvalid, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_ostate", bus.ostate, 128'h0);
    chk("reset_mout", bus.mout, 32'h0);
    chk("reset_mcol", bus.mcol, 2'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_vec("v1", {4{32'h8e4da1bc}}, {4{32'hdb135345}}, 1, 1'b0);
    run_vec("v2", 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6,
                  128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1, 1'b0);
    run_vec("v3_held", {4{32'h8e4da1bc}}, {4{32'hdb135345}}, 40, 1'b0);
    run_vec("v3_again", {4{32'h8e4da1bc}}, {4{32'hdb135345}}, 1, 1'b0);
    reset_mid_run(128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6);
    run_vec("v4_after_rst", {4{32'h4d7ebdf8}}, {4{32'h2d26314c}}, 1, 1'b0);
    run_vec("v5_toggle", 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6,
                         128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rnd_st = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_vec("rand", rnd_st, model(rnd_st ^ rkey_v), 1, 1'b0);
    end
`ifdef INV_MIX_ADDKEY_EN
    rkey_v = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
    run_vec("v6_zero", 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6, 128'h0, 1, 1'b0);
    rkey_v = {4{32'h00000001}};
    run_vec("v6_key", {4{32'h8e4da1bd}}, {4{32'hdb135345}}, 1, 1'b0);
    rkey_v = 128'h0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
